// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART blocks.
// The UART_RX_PARITY_EN build uses the PARITY state; the default build never enters it.
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT   = 62500000;
  localparam int BAUD_DEFAULT       = 115200;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  // Rounded clocks-per-tick, never below one so the divider always advances.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    longint den;
    longint d;
    den = longint'(baud) * longint'(oversample);
    d   = (longint'(clk_freq) + den / 64'sd2) / den;
    if (d < 64'sd1) begin
      d = 64'sd1;
    end
    return int'(d);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one registered tick every DIV clocks.
// A clear restarts the phase so ticks line up with an external event.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(DIV + 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_r;
  logic         tick_r;

  // Divider counter with wrap at DIV-1 and phase restart on clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + W'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver, 16x oversampled with a 3-sample mid-bit majority vote; 8N1 by default.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD       = BAUD_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] IDX_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] IDX_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] IDX_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] IDX_LAST = TW'(OVERSAMPLE - 1);

  uart_state_e   state_r;
  logic          rx_meta_r;
  logic          rx_s;
  logic [TW-1:0] tick_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [1:0]    samp_r;
  logic [7:0]    shift_r;
  logic [7:0]    data_r;
  logic          ready_r;
  logic          frame_err_r;
  logic          busy_r;
`ifdef UART_RX_PARITY_EN
  logic          par_err_r;
`endif

  logic tick_s;
  logic clear_s;
  logic vote_s;
  logic at_vote_s;
  logic bit_end_s;

  // Restarting the divider on the start edge aligns the bit phase to that edge.
  assign clear_s   = (state_r == IDLE) && !rx_s;
  assign vote_s    = majority3(samp_r[0], samp_r[1], rx_s);
  assign at_vote_s = tick_s && (tick_cnt_r == IDX_VOTE);
  assign bit_end_s = tick_s && (tick_cnt_r == IDX_LAST);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Synchroniser, tick/bit counters, vote samples and the frame state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rx_meta_r   <= 1'b1;
      rx_s        <= 1'b1;
      tick_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      samp_r      <= 2'b11;
      shift_r     <= 8'h00;
      data_r      <= 8'h00;
      ready_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r   <= 1'b0;
`endif
    end else begin
      rx_meta_r   <= rx;
      rx_s        <= rx_meta_r;
      ready_r     <= 1'b0;
      frame_err_r <= 1'b0;

      if ((state_r != IDLE) && tick_s) begin
        tick_cnt_r <= (tick_cnt_r == IDX_LAST) ? '0 : tick_cnt_r + TW'(1);
        if (tick_cnt_r == IDX_S0) begin
          samp_r[0] <= rx_s;
        end
        if (tick_cnt_r == IDX_S1) begin
          samp_r[1] <= rx_s;
        end
      end

      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r    <= START;
            busy_r     <= 1'b1;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_err_r  <= 1'b0;
`endif
          end
        end
        START: begin
          if (at_vote_s && vote_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (bit_end_s) begin
            state_r   <= DATA;
            bit_cnt_r <= 3'd0;
          end
        end
        DATA: begin
          if (at_vote_s) begin
            shift_r <= {vote_s, shift_r[7:1]};
          end
          if (bit_end_s) begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_r   <= PARITY;
`else
              state_r   <= STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_vote_s) begin
            par_err_r <= vote_s ^ (^shift_r);
          end
          if (bit_end_s) begin
            state_r <= STOP;
          end
        end
`endif
        STOP: begin
          // Return to IDLE at the vote so a following start bit is not missed.
          if (at_vote_s) begin
            if (!vote_s) begin
              frame_err_r <= 1'b1;
              state_r     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (par_err_r) begin
              frame_err_r <= 1'b1;
              state_r     <= IDLE;
              busy_r      <= 1'b0;
`endif
            end else begin
              data_r  <= shift_r;
              ready_r <= 1'b1;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_r;
  assign ready     = ready_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: frame-level scoreboard plus directed and random frames.
// Honours UART_RX_PARITY_EN to add the parity bit and parity cases.
module tb_uart_rx_oversample;

  localparam int CLK_FREQ = 1843200;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int BIT      = CLK_FREQ / (BAUD * OS) * OS;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // Stop-bit centre sits about 9.5 bit times after the start edge, plus sync delay.
  localparam int LAT_LO = 150 + BIT * EXTRA;
  localparam int LAT_HI = 166 + BIT * EXTRA;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  int         n_ready = 0;
  int         n_ferr  = 0;
  int         lat;
  logic [7:0] model_data = 8'h00;

  uart_rx_oversample #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .ready     (ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outcome comes from the frame rules: good stop and good parity give data.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    bit ok;
    ok = (stop_b == 1'b1);
`ifdef UART_RX_PARITY_EN
    ok = ok && (par_b == ^d);
`endif
    exp_q.push_back('{is_err: !ok, d: d, start: cyc});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  // Per-cycle compare against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        model_data = 8'h00;
      end else begin
        check("ready_ferr_exclusive", 32'(ready & frame_err), 32'd0);
        if (ready || frame_err) begin
          if (ready) n_ready++;
          if (frame_err) n_ferr++;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind_is_err", 32'(frame_err), 32'(e.is_err));
            if (!e.is_err) begin
              model_data = e.d;
              check("busy_low_at_ready", 32'(busy), 32'd0);
            end
            lat = cyc - e.start;
            check("latency_in_window", 32'(lat >= LAT_LO && lat <= LAT_HI), 32'd1);
          end
        end
        check("data_vs_model", 32'(data), 32'(model_data));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       bad;
    logic       par;
    int         r0;
    int         f0;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Single byte.
    send_frame(8'h61, 1'b1, ^8'h61);
    idle(40);
    @(negedge clk);
    check("single_data_61", 32'(data), 32'h61);
    check("single_busy", 32'(busy), 32'd0);
    check("single_counts", 32'(n_ready * 16 + n_ferr), 32'd16);
    @(posedge clk);
    #1;

    // Back-to-back frames.
    send_frame(8'h30, 1'b1, ^8'h30);
    send_frame(8'h66, 1'b1, ^8'h66);
    idle(40);
    @(negedge clk);
    check("b2b_data_66", 32'(data), 32'h66);
    check("b2b_ready_count", 32'(n_ready), 32'd3);
    @(posedge clk);
    #1;

    // Glitch shorter than the mid-bit vote.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (BIT + 4) @(posedge clk);
    #1;
    @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_pulse", 32'(n_ready * 16 + n_ferr), 32'd48);
    @(posedge clk);
    #1;

    // Bad stop bit followed by a break.
    send_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    #1;
    @(negedge clk);
    check("break_ferr_count", 32'(n_ferr), 32'd1);
    check("break_busy", 32'(busy), 32'd1);
    check("break_data_kept", 32'(data), 32'h66);
    @(posedge clk);
    #1;
    idle(2 * BIT);
    @(negedge clk);
    check("break_release_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send_frame(8'h41, 1'b1, ^8'h41);
    idle(40);
    @(negedge clk);
    check("after_break_data_41", 32'(data), 32'h41);
    check("after_break_ferr", 32'(n_ferr), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of data bit 4 of 0xA5.
    r0 = n_ready;
    f0 = n_ferr;
    d  = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT / 2) @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_ready", 32'(ready), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    idle(40);
    @(negedge clk);
    check("midreset_no_pulse", 32'((n_ready - r0) + (n_ferr - f0)), 32'd0);
    @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(40);
    @(negedge clk);
    check("after_reset_data_5a", 32'(data), 32'h5A);
    @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    idle(40);
    @(negedge clk);
    check("parity_good_data_03", 32'(data), 32'h03);
    @(posedge clk);
    #1;
    f0 = n_ferr;
    send_frame(8'h03, 1'b1, 1'b1);
    idle(40);
    @(negedge clk);
    check("parity_bad_ferr", 32'(n_ferr - f0), 32'd1);
    check("parity_bad_data_kept", 32'(data), 32'h03);
    @(posedge clk);
    #1;
`endif

    // Random frames with occasional bad stop (and bad parity when enabled).
    for (int k = 0; k < 30; k++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      par = ^d;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 5) == 0) par = ~par;
`endif
      send_frame(d, !bad, par);
      if (bad) begin
        idle(BIT + $urandom_range(0, 20));
      end else begin
        idle($urandom_range(0, 20));
      end
    end

    idle(200);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART receiver that turns the asynchronous serial line into byte strobes.
- Sits directly upstream of the serial-boot loader and other UART byte consumers.
- Output: 8-bit data plus a one-cycle `ready` pulse per valid frame.
- Frame format 8N1, LSB first; 16x oversampling with majority-vote sampling; framing errors reported and never forwarded as data.

Parameters:
- CLK_FREQ, 62500000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; must be an even value of 8 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- rx  input  1  asynchronous serial line; idle high
- data  output  8  last correctly received byte; holds its value between frames
- ready  output  1  one-cycle pulse; `data` is valid in the same cycle
- frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity when enabled)
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values:
  - data = 8'h00; ready = 0; frame_err = 0; busy = 0.
  - State = IDLE; both synchroniser flops = 1; tick divider = 0; tick counter = 0; bit counter = 0.
- Synchroniser:
  - rx passes through a 2-flop synchroniser; rx_s is the second flop.
  - All decisions use rx_s, so there is 2 cycles of input latency.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)), clamped to a minimum of 1.
  - Divider width is clog2(DIV+1).
  - `tick` pulses once every DIV clocks.
  - The divider is cleared on the IDLE->START transition, so the bit phase aligns to the start edge.
- Mid-bit sample:
  - A 3-sample majority vote of rx_s, taken on tick indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit.
  - The tick counter counts 0..OVERSAMPLE-1 and wraps to 0 at the bit boundary.
- State machine:
  - IDLE: when rx_s==0, go to START and clear the tick counter.
  - START: at tick index OVERSAMPLE/2+1, evaluate the vote.
    - Vote 1: false start (glitch); return to IDLE with no pulse.
    - Vote 0: continue; at the bit end go to DATA with bit counter = 0.
  - DATA: at each mid-bit vote, shift the vote into the MSB of the shift register (LSB-first reception).
    - At the bit end the bit counter increments.
    - After bit 7, go to STOP.
  - STOP: at the mid-bit vote:
    - Vote 1: `data` <= shift register; `ready` = 1 on the next clock edge; go to IDLE immediately without waiting for the full stop bit. This allows back-to-back frames with one stop bit.
    - Vote 0: `frame_err` = 1 for one cycle; `data` is unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s==1 (covers break conditions), then go to IDLE. No pulses are generated while here.
- ready and frame_err are never high in the same cycle; each lasts exactly one clk.
- No backpressure: the consumer must capture `data` on `ready`. `data` stays stable until the next valid frame.
- Latency: `ready` rises 1 clk after the stop-bit vote tick; this is about 9.5 bit times after the start edge, plus 2 synchroniser cycles.
- Reset mid-frame: the frame is abandoned and no pulse is produced. A line that is still low after reset is treated as a new start edge.
- Counters use unsigned arithmetic with explicit wrap; no counter saturates.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, using even parity.
  - The voted parity bit must equal the XOR of the 8 data bits.
  - On mismatch: frame_err pulses at the STOP vote (even if the stop bit is good) and `data` is not updated.
  - Frame becomes 8E1.
- Undefined: no PARITY state; 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - State encoding enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE.
  - Constant defaults.
- One sub-module, uart_baud_tick:
  - Parameter DIV.
  - Inputs clk, rst, clear; output tick.
  - Reusable by a future transmitter.

Test Plan:
- Bench config CLK_FREQ=1843200, BAUD=115200: gives DIV=1.
- Single byte: send 0x61 ('a') 8N1 -> exactly one `ready` pulse with data=8'h61; frame_err stays 0; busy falls after the pulse.
- Back-to-back: send 0x30 then 0x66 with one stop bit and no idle gap -> two `ready` pulses with data 8'h30 then 8'h66, about 10 bit times apart.
- Glitch: rx low for 4 ticks, then high -> no `ready`, no `frame_err`; busy returns to 0 within one bit time.
- Framing and break:
  - Send 0x55 with stop bit = 0 -> one frame_err pulse, no `ready`, data keeps its previous value.
  - Hold rx low for 3 bit times -> no further pulses until rx goes high.
  - A subsequent 0x41 is received correctly.
- Reset mid-frame: assert rst during data bit 4 of 0xA5 -> no pulse; outputs at reset values; a next frame 0x5A yields data=8'h5A.
- UART_RX_PARITY_EN:
  - 0x03 with parity 0 -> ready, data=8'h03.
  - 0x03 with parity 1 -> frame_err, no ready.
